// File: rtl/i2s_rx_ctrl.sv
// rtl/i2s_rx_ctrl.sv - I2S receive-path master sequencer: ws timing, stereo pair capture, handshake, overrun
module i2s_rx_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLOT  = 32,
    parameter int CNTW  = 16
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_ovr,
    output logic             ws,
    input  logic [WIDTH-1:0] rx_left,
    input  logic [WIDTH-1:0] rx_right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_left,
    output logic [WIDTH-1:0] out_right,
    output logic             overrun,
    output logic             busy,
    output logic [CNTW-1:0]  pair_cnt
);

    localparam int CW = $clog2(2 * SLOT);

    // Frame positions of interest within the 2*SLOT cycle frame
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * SLOT - 1);
    localparam logic [CW-1:0] CNT_CAP  = CW'(2);
    localparam logic [CW-1:0] CNT_HALF = CW'(SLOT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          ws_nxt;
    logic          frame_end;
    logic          capture;
    logic          accept;

    // State, bit counter and word select registers
    always_ff @(posedge sclk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ws    <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ws    <= ws_nxt;
        end
    end

    // Next-state, next counter/ws and capture strobe
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        frame_end = (cnt == CNT_LAST);

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                // First frame's receiver words are incomplete; the capture slot is skipped
                if (cnt == CNT_CAP) begin
                    state_nxt = en ? RUN : STOP;
                end
            end
            RUN: begin
                capture = (cnt == CNT_CAP);
                if (!en) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Finish the current frame so the codec sees a whole ws period
                capture = (cnt == CNT_CAP);
                if (en) begin
                    state_nxt = RUN;
                end else if (frame_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state == IDLE || state_nxt == IDLE) begin
            cnt_nxt = '0;
        end else if (frame_end) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end

        // ws is computed from the next count so the register lines up with cnt
        ws_nxt = (state_nxt == IDLE) ? 1'b1 : (cnt_nxt >= CNT_HALF);
    end

    assign accept = out_valid && out_ready;
    assign busy   = (state != IDLE);

    // Output pair register, valid/ready handshake and delivered-pair counter
    always_ff @(posedge sclk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            pair_cnt  <= '0;
        end else begin
            if (accept) begin
                pair_cnt <= pair_cnt + CNTW'(1);
            end
            if (capture) begin
                // A held pair that is not being taken wins; the new one is dropped
                if (!out_valid || out_ready) begin
                    out_left  <= rx_left;
                    out_right <= rx_right;
                end
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sticky overrun flag; a new drop takes priority over a clear request
    always_ff @(posedge sclk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (capture && out_valid && !out_ready) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// tb/tb_i2s_rx_ctrl.sv - self-checking bench for i2s_rx_ctrl against a frame-position reference model
module tb_i2s_rx_ctrl;

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr_ovr = 1'b0;
    logic        ws;
    logic [15:0] rx_l = 16'h0;
    logic [15:0] rx_r = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        overrun;
    logic        busy;
    logic [15:0] pair_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_rx = 1'b0;

    // Reference model: active flag, position within the 64-cycle frame, priming and stop flags
    bit          m_active = 0;
    int          m_pos = 0;
    bit          m_discard = 0;
    bit          m_stopping = 0;
    bit          m_valid = 0;
    logic [15:0] m_l = 0;
    logic [15:0] m_r = 0;
    bit          m_ovr = 0;
    logic [15:0] m_pairs = 0;

    i2s_rx_ctrl #(.WIDTH(16), .SLOT(32), .CNTW(16)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .en        (en),
        .clr_ovr   (clr_ovr),
        .ws        (ws),
        .rx_left   (rx_l),
        .rx_right  (rx_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_left  (out_left),
        .out_right (out_right),
        .overrun   (overrun),
        .busy      (busy),
        .pair_cnt  (pair_cnt)
    );

    always #5 sclk = ~sclk;

    function automatic bit exp_ws();
        return m_active ? (m_pos >= 32) : 1'b1;
    endfunction

    function automatic void model_step();
        bit cap;
        bit acc;
        bit old_stop;
        if (rst) begin
            m_active = 0; m_pos = 0; m_discard = 0; m_stopping = 0;
            m_valid = 0; m_l = 0; m_r = 0; m_ovr = 0; m_pairs = 0;
            return;
        end
        cap = m_active && !m_discard && (m_pos == 2);
        acc = m_valid && out_ready;
        if (acc) m_pairs = m_pairs + 16'd1;
        if (cap && m_valid && !out_ready) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
        if (cap && (!m_valid || out_ready)) begin
            m_l = rx_l;
            m_r = rx_r;
        end
        m_valid = cap ? 1'b1 : (acc ? 1'b0 : m_valid);
        if (!m_active) begin
            if (en) begin
                m_active = 1; m_pos = 0; m_discard = 1; m_stopping = 0;
            end
        end else begin
            old_stop = m_stopping;
            if (m_discard) begin
                if (m_pos == 2) begin
                    m_discard = 0;
                    m_stopping = !en;
                end
            end else begin
                m_stopping = !en;
            end
            if (old_stop && !en && m_pos == 63) begin
                m_active = 0; m_pos = 0; m_stopping = 0;
            end else begin
                m_pos = (m_pos == 63) ? 0 : m_pos + 1;
            end
        end
    endfunction

    // One clock: the model follows the same edge, inputs change on the falling edge
    task automatic tick();
        @(posedge sclk);
        model_step();
        @(negedge sclk);
        if (rand_rx && m_active && m_pos == 32) begin
            rx_l = 16'($urandom);
            rx_r = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (ws !== 1'b1) begin n_errors++; $display("FAIL reset_ws got %b want 1", ws); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
        n_checks++; if (pair_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt got %0d want 0", pair_cnt); end
        n_checks++; if (out_left !== 16'd0 || out_right !== 16'd0) begin n_errors++; $display("FAIL reset_data got %h/%h want 0/0", out_left, out_right); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_startup();
        int first;
        first = -1;
        rx_l = 16'hA5A5;
        rx_r = 16'h5A5A;
        out_ready = 1'b1;
        en = 1'b1;
        tick();
        n_checks++; if (ws !== 1'b0) begin n_errors++; $display("FAIL start_ws got %b want 0", ws); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL start_busy got %b want 1", busy); end
        for (int i = 1; i <= 200 && first < 0; i++) begin
            tick();
            n_checks++; if (ws !== exp_ws()) begin n_errors++; $display("FAIL start_ws_cyc%0d got %b want %b", i, ws, exp_ws()); end
            n_checks++; if (out_valid !== m_valid) begin n_errors++; $display("FAIL start_valid_cyc%0d got %b want %b", i, out_valid, m_valid); end
            if (out_valid === 1'b1) first = i;
        end
        n_checks++; if (first != 67) begin n_errors++; $display("FAIL first_pair_cycle got %0d want 67", first); end
        n_checks++; if (out_left !== 16'hA5A5 || out_right !== 16'h5A5A) begin n_errors++; $display("FAIL first_pair_data got %h/%h want a5a5/5a5a", out_left, out_right); end
        tick();
        n_checks++; if (pair_cnt !== 16'd1) begin n_errors++; $display("FAIL first_pair_cnt got %0d want 1", pair_cnt); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL first_pair_drain got %b want 0", out_valid); end
        rand_rx = 1'b1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 192; i++) begin
            tick();
            n_checks++; if (out_valid !== m_valid) begin n_errors++; $display("FAIL bp_valid_cyc%0d got %b want %b", i, out_valid, m_valid); end
            n_checks++; if (m_valid && (out_left !== m_l || out_right !== m_r)) begin n_errors++; $display("FAIL bp_data_cyc%0d got %h/%h want %h/%h", i, out_left, out_right, m_l, m_r); end
            n_checks++; if (overrun !== m_ovr) begin n_errors++; $display("FAIL bp_ovr_cyc%0d got %b want %b", i, overrun, m_ovr); end
        end
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL bp_overrun_set got %b want 1", overrun); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL bp_overrun_clr got %b want 0", overrun); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_still_held got %b want 1", out_valid); end
    endtask

    task automatic test_back_to_back();
        bit          found;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        logic [15:0] prev;
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (m_pos == 2) found = 1;
            else tick();
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL b2b_wait got timeout want capture slot"); end
        out_ready = 1'b1;
        exp_l = rx_l;
        exp_r = rx_r;
        prev = m_pairs;
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid got %b want 1", out_valid); end
        n_checks++; if (out_left !== exp_l || out_right !== exp_r) begin n_errors++; $display("FAIL b2b_data got %h/%h want %h/%h", out_left, out_right, exp_l, exp_r); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL b2b_ovr got %b want 0", overrun); end
        n_checks++; if (pair_cnt !== prev + 16'd1) begin n_errors++; $display("FAIL b2b_cnt got %0d want %0d", pair_cnt, prev + 16'd1); end
        tick();
    endtask

    task automatic test_stop();
        bit          found;
        logic [15:0] pc;
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (m_pos == 40) found = 1;
            else tick();
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL stop_wait got timeout want cnt 40"); end
        en = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            tick();
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL stop_busy_k%0d got %b want 1", k, busy); end
            n_checks++; if (ws !== 1'b1) begin n_errors++; $display("FAIL stop_ws_k%0d got %b want 1", k, ws); end
        end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL stop_idle got %b want 0", busy); end
        n_checks++; if (ws !== 1'b1) begin n_errors++; $display("FAIL stop_idle_ws got %b want 1", ws); end
        pc = m_pairs;
        for (int i = 0; i < 150; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0 || ws !== 1'b1) begin n_errors++; $display("FAIL idle_quiet_cyc%0d got v=%b ws=%b want v=0 ws=1", i, out_valid, ws); end
        end
        n_checks++; if (pair_cnt !== pc) begin n_errors++; $display("FAIL idle_cnt got %0d want %0d", pair_cnt, pc); end
        en = 1'b1;
        tick();
        for (int i = 1; i <= 67; i++) begin
            tick();
            n_checks++; if (out_valid !== m_valid) begin n_errors++; $display("FAIL restart_valid_cyc%0d got %b want %b", i, out_valid, m_valid); end
            n_checks++; if (ws !== exp_ws()) begin n_errors++; $display("FAIL restart_ws_cyc%0d got %b want %b", i, ws, exp_ws()); end
            if (i == 3) begin
                n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL prime_discard got %b want 0", out_valid); end
            end
        end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL restart_pair got %b want 1", out_valid); end
    endtask

    task automatic test_reenter();
        logic [15:0] pc;
        for (int i = 0; i < 80 && m_pos != 5; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 10 && m_pos != 10; i++) tick();
        en = 1'b1;
        pc = m_pairs;
        for (int i = 0; i < 64; i++) begin
            tick();
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL reenter_busy_cyc%0d got %b want 1", i, busy); end
            n_checks++; if (ws !== exp_ws()) begin n_errors++; $display("FAIL reenter_ws_cyc%0d got %b want %b", i, ws, exp_ws()); end
        end
        n_checks++; if (pair_cnt !== pc + 16'd1) begin n_errors++; $display("FAIL reenter_cnt got %0d want %0d", pair_cnt, pc + 16'd1); end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_pos == 20 && m_valid) found = 1;
            else tick();
        end
        n_checks++; if (!found || out_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_setup got found=%0d v=%b want 1/1", found, out_valid); end
        rst = 1'b1;
        tick();
        n_checks++; if (ws !== 1'b1) begin n_errors++; $display("FAIL rstmid_ws got %b want 1", ws); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        n_checks++; if (pair_cnt !== 16'd0) begin n_errors++; $display("FAIL rstmid_cnt got %0d want 0", pair_cnt); end
        n_checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin n_errors++; $display("FAIL rstmid_flags got busy=%b ovr=%b want 0/0", busy, overrun); end
        rst = 1'b0;
        en = 1'b0;
        tick();
    endtask

    initial begin
        @(negedge sclk);
        test_reset();
        test_startup();
        test_backpressure();
        test_back_to_back();
        test_stop();
        test_reenter();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
